key_debounce: RTL and testbench

//  Input conditioner that sits directly upstream of the nios_sys PIO inputs.
//  - Synchronises the raw, active-low push-button lines into the 50 MHz domain.
//  - Debounces each key independently.
//  - Emits a clean level plus one-cycle press/release pulses per key.
//  - Optionally holds sticky edge-capture bits that software clears.

---
 rtl/key_debounce.sv | 124 ++++++++++++
 tb/tb_key_debounce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, per-key debounce FSM, press/release pulses.
// Optional sticky press capture enabled by defining EDGE_CAPTURE_EN.
module key_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n_in,
    input  logic [N_KEYS-1:0] edge_clear,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] edge_capture
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } state_t;

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_sample;

    state_t            r_state     [N_KEYS];
    state_t            w_state_nxt [N_KEYS];
    logic [CNT_W-1:0]  r_cnt       [N_KEYS];
    logic [CNT_W-1:0]  w_cnt_nxt   [N_KEYS];

    logic [N_KEYS-1:0] w_press_nxt;
    logic [N_KEYS-1:0] w_release_nxt;
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;

    // Synchronisers idle at 1 so a reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = ~r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                r_state[i] <= ST_UP;
                r_cnt[i]   <= '0;
            end
            r_press   <= '0;
            r_release <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples;
    // the counter clears on every toggle, so it can never wrap.
    always_comb begin
        w_press_nxt   = '0;
        w_release_nxt = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = '0;
            if (w_sample[i] != (r_state[i] == ST_DOWN)) begin
                if (r_cnt[i] == CNT_LAST) begin
                    if (r_state[i] == ST_UP) begin
                        w_state_nxt[i] = ST_DOWN;
                        w_press_nxt[i] = 1'b1;
                    end else begin
                        w_state_nxt[i]   = ST_UP;
                        w_release_nxt[i] = 1'b1;
                    end
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        key_level = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            key_level[i] = (r_state[i] == ST_DOWN);
        end
    end

    assign key_press   = r_press;
    assign key_release = r_release;

`ifdef EDGE_CAPTURE_EN
    logic [N_KEYS-1:0] r_capture;

    // Set term is OR-ed last so a press coinciding with a clear keeps the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_capture <= '0;
        end else begin
            r_capture <= (r_capture & ~edge_clear) | r_press;
        end
    end

    assign edge_capture = r_capture;
`else
    logic w_unused_clear;

    assign w_unused_clear = ^edge_clear;
    assign edge_capture   = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed + randomized bench for key_debounce (N_KEYS=4, DEBOUNCE_CYCLES=8) against a window-based model.
module tb_key_debounce;

    localparam int N = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] key_n_in;
    logic [N-1:0] edge_clear;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] edge_capture;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: raw-line delay, last D samples per key, expected outputs.
    logic [N-1:0] m_d1, m_d2;
    logic [D-1:0] m_hist [N];
    logic [N-1:0] m_lvl, m_prs, m_rel, m_cap;

    key_debounce #(
        .N_KEYS         (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n_in    (key_n_in),
        .edge_clear  (edge_clear),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .edge_capture(edge_capture)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Level flips once the last D synchronised samples all disagree with it.
    task automatic model_edge();
        logic [N-1:0] s;
        if (reset) begin
            m_d1 = '1;
            m_d2 = '1;
            m_lvl = '0;
            m_prs = '0;
            m_rel = '0;
            m_cap = '0;
            for (int i = 0; i < N; i++) m_hist[i] = '0;
        end else begin
            s = ~m_d2;
`ifdef EDGE_CAPTURE_EN
            m_cap = (m_cap & ~edge_clear) | m_prs;
`else
            m_cap = '0;
`endif
            m_d2 = m_d1;
            m_d1 = key_n_in;
            m_prs = '0;
            m_rel = '0;
            for (int i = 0; i < N; i++) begin
                m_hist[i] = {m_hist[i][D-2:0], s[i]};
                if (!m_lvl[i] && (m_hist[i] == {D{1'b1}})) begin
                    m_lvl[i] = 1'b1;
                    m_prs[i] = 1'b1;
                end else if (m_lvl[i] && (m_hist[i] == {D{1'b0}})) begin
                    m_lvl[i] = 1'b0;
                    m_rel[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input logic rst_v, input logic [N-1:0] kn, input logic [N-1:0] clr);
        reset      = rst_v;
        key_n_in   = kn;
        edge_clear = clr;
        @(posedge clk);
        #1;
        model_edge();
        chk("level",   key_level,    m_lvl);
        chk("press",   key_press,    m_prs);
        chk("release", key_release,  m_rel);
        chk("capture", edge_capture, m_cap);
        chk("press_and_release", |(key_press & key_release), 0);
    endtask

    initial begin
        int first, p2, p3, r2, r3, seen;
        logic [N-1:0] kn;

        reset      = 1'b1;
        key_n_in   = '1;
        edge_clear = '0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1111, 4'b0000);

        // Scenario 1: quiet after reset release
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 4'b1111, 4'b0000);
            if (i % 10 == 0)
                chk("s1_quiet", {key_level, key_press, key_release, edge_capture}, 0);
        end

        // Scenario 2: key 0 pressed and held
        first = 0;
        for (int n = 1; n <= 20 && first == 0; n++) begin
            cyc(1'b0, 4'b1110, 4'b0000);
            if (key_press[0]) first = n;
        end
        chk("s2_latency", first, 10);
        chk("s2_level", key_level[0], 1);
        cyc(1'b0, 4'b1110, 4'b0000);
        chk("s2_single_pulse", key_press[0], 0);

        // Scenario 3: key 1 bouncing every 3 cycles
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            cyc(1'b0, ((n / 3) % 2 == 0) ? 4'b1100 : 4'b1110, 4'b0000);
            seen += int'(key_press[1] | key_release[1] | key_level[1]);
        end
        for (int n = 0; n < 15; n++) begin
            cyc(1'b0, 4'b1110, 4'b0000);
            seen += int'(key_press[1] | key_release[1] | key_level[1]);
        end
        chk("s3_bounce_rejected", seen, 0);

        // Scenario 4: keys 2 and 3 together, then everything released
        p2 = 0; p3 = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b0, 4'b0010, 4'b0000);
            if (key_press[2]) p2 = n;
            if (key_press[3]) p3 = n;
        end
        chk("s4_press_k2", p2, 10);
        chk("s4_press_k3", p3, 10);
        r2 = 0; r3 = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b0, 4'b1111, 4'b0000);
            if (key_release[2]) r2 = n;
            if (key_release[3]) r3 = n;
        end
        chk("s4_release_k2", r2, 10);
        chk("s4_release_k3", r3, 10);
        chk("s4_level_idle", key_level, 4'b0000);

`ifdef EDGE_CAPTURE_EN
        // Scenario 5: clear coinciding with a press loses to the set
        for (int n = 0; n < 12; n++) cyc(1'b0, 4'b1110, 4'b0000);
        for (int n = 0; n < 12; n++) cyc(1'b0, 4'b1111, 4'b0000);
        chk("s5_first_capture", edge_capture[0], 1);
        first = 0;
        for (int n = 1; n <= 20 && first == 0; n++) begin
            cyc(1'b0, 4'b1110, 4'b0000);
            if (key_press[0]) first = n;
        end
        chk("s5_second_press", first, 10);
        cyc(1'b0, 4'b1110, 4'b0001);
        chk("s5_set_wins", edge_capture[0], 1);
        cyc(1'b0, 4'b1110, 4'b0001);
        chk("s5_lone_clear", edge_capture[0], 0);
`endif

        // Scenario 6: reset in the middle of a count on a held key
        for (int n = 0; n < 15; n++) cyc(1'b0, 4'b1111, 4'b0000);
        for (int n = 0; n < 5; n++) cyc(1'b0, 4'b1110, 4'b0000);
        for (int n = 0; n < 3; n++) begin
            cyc(1'b1, 4'b1110, 4'b0000);
            chk("s6_in_reset", {key_level, key_press, key_release, edge_capture}, 0);
        end
        first = 0;
        seen  = 0;
        for (int n = 1; n <= 20 && first == 0; n++) begin
            cyc(1'b0, 4'b1110, 4'b0000);
            if (key_press[0]) first = n;
            seen += int'(|key_release);
        end
        chk("s6_press_after_reset", first, 10);
        chk("s6_no_release", seen, 0);

        // Randomized phase: independent key toggles and clears
        kn = 4'b1111;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) kn[i] = ~kn[i];
            cyc(1'b0, kn, N'($urandom_range(0, 15)) & {N{($urandom_range(0, 3) == 0)}});
        end
        for (int n = 0; n < 20; n++) cyc(1'b0, 4'b1111, 4'b0000);
        chk("final_idle", key_level, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
